div32_issue_ctrl: RTL and testbench

- Request sequencer directly upstream of the 32-bit unsigned sequential divider core. Feeds the core's dividend/divisor/start inputs and consumes its quotient/remainder/finish outputs.
- Accepts signed or unsigned 32-bit divide requests over a valid/ready handshake. Converts operands to magnitudes, launches the core, waits for finish, applies sign correction, and returns a registered result over a second valid/ready handshake.
- Resolves divide-by-zero and signed overflow locally without launching the core.

---
 rtl/div32_issue_ctrl_if.sv | 39 +++
 rtl/div32_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_div32_issue_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div32_issue_ctrl_if.sv
// Request/response handshake and divider-core link for div32_issue_ctrl.
// slave is the sequencer's view; master is the requester/core side.
interface div32_issue_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;

  logic        core_start;
  logic [63:0] core_dividend;
  logic [31:0] core_divisor;
  logic        core_finish;
  logic [32:0] core_quo;
  logic [31:0] core_rem;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_quo;
  logic [31:0] resp_rem;
  logic        resp_div_zero;
  logic        resp_overflow;
  logic        resp_timeout;
  logic        busy;

  modport slave (
    input  req_valid, req_signed, req_dividend, req_divisor,
    input  core_finish, core_quo, core_rem, resp_ready,
    output req_ready, core_start, core_dividend, core_divisor,
    output resp_valid, resp_quo, resp_rem, resp_div_zero, resp_overflow, resp_timeout, busy
  );

  modport master (
    output req_valid, req_signed, req_dividend, req_divisor,
    output core_finish, core_quo, core_rem, resp_ready,
    input  req_ready, core_start, core_dividend, core_divisor,
    input  resp_valid, resp_quo, resp_rem, resp_div_zero, resp_overflow, resp_timeout, busy
  );
endinterface

// File: rtl/div32_issue_ctrl.sv
// Signed/unsigned request sequencer in front of the 32-bit unsigned sequential divider core.
// Handles divide-by-zero and signed overflow locally; sign-corrects core results.
module div32_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 96
) (
  input logic               clk,
  input logic               rst,
  div32_issue_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StFix, StResp} state_e;

  state_e          state_q, state_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [31:0]     mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [31:0]     quo_q, quo_d, rem_q, rem_d;
  logic            dz_q, dz_d, ov_q, ov_d, to_q, to_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            sa, sb;
  logic [31:0]     ma, mb;

  always_comb begin
    sa = bus.req_signed & bus.req_dividend[31];
    sb = bus.req_signed & bus.req_divisor[31];
    ma = sa ? (~bus.req_dividend + 32'd1) : bus.req_dividend;
    mb = sb ? (~bus.req_divisor + 32'd1) : bus.req_divisor;
  end

  always_comb begin
    state_d        = state_q;
    sign_a_d       = sign_a_q;
    sign_b_d       = sign_b_q;
    mag_a_d        = mag_a_q;
    mag_b_d        = mag_b_q;
    quo_d          = quo_q;
    rem_d          = rem_q;
    dz_d           = dz_q;
    ov_d           = ov_q;
    to_d           = to_q;
    cnt_d          = cnt_q;
    bus.req_ready  = 1'b0;
    bus.core_start = 1'b0;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          sign_a_d = sa;
          sign_b_d = sb;
          mag_a_d  = ma;
          mag_b_d  = mb;
          dz_d     = 1'b0;
          ov_d     = 1'b0;
          to_d     = 1'b0;
          if (bus.req_divisor == 32'd0) begin
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = bus.req_dividend;
            dz_d    = 1'b1;
            state_d = StResp;
          end else if (bus.req_signed && bus.req_dividend == 32'h8000_0000 &&
                       bus.req_divisor == 32'hFFFF_FFFF) begin
            quo_d   = 32'h8000_0000;
            rem_d   = 32'd0;
            ov_d    = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StLaunch;
          end
        end
      end
      StLaunch: begin
        bus.core_start = 1'b1;
        cnt_d          = '0;
        state_d        = StWait;
      end
      StWait: begin
        // First WAIT cycle may still show finish left over from the previous op.
        if (cnt_q != '0 && bus.core_finish) begin
          quo_d   = bus.core_quo[31:0];
          rem_d   = bus.core_rem;
          state_d = StFix;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          quo_d   = 32'd0;
          rem_d   = 32'd0;
          to_d    = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StFix: begin
        quo_d   = (sign_a_q ^ sign_b_q) ? (~quo_q + 32'd1) : quo_q;
        rem_d   = sign_a_q ? (~rem_q + 32'd1) : rem_q;
        state_d = StResp;
      end
      StResp: begin
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      mag_a_q  <= 32'd0;
      mag_b_q  <= 32'd0;
      quo_q    <= 32'd0;
      rem_q    <= 32'd0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
      to_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dz_q     <= dz_d;
      ov_q     <= ov_d;
      to_q     <= to_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.resp_valid    = (state_q == StResp);
  assign bus.resp_quo      = quo_q;
  assign bus.resp_rem      = rem_q;
  assign bus.resp_div_zero = bus.resp_valid & dz_q;
  assign bus.resp_overflow = bus.resp_valid & ov_q;
  assign bus.resp_timeout  = bus.resp_valid & to_q;
  assign bus.busy          = (state_q != StIdle);
  assign bus.core_dividend = {32'd0, mag_a_q};
  assign bus.core_divisor  = mag_b_q;

endmodule

// File: tb/tb_div32_issue_ctrl.sv
// Directed bench for div32_issue_ctrl: vector table plus multi-cycle corner sequences,
// with a behavioural divider core (normal, finish stuck high, finish stuck low).
module tb_div32_issue_ctrl;
  localparam int unsigned T = 96;
  localparam int CoreLat = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div32_issue_ctrl_if bus ();

  div32_issue_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Core model: 0 = finish after CoreLat cycles, 1 = finish stuck high, 2 = stuck low.
  int          core_mode = 0;
  int          core_cnt  = 0;
  int          start_cnt = 0;
  logic [63:0] seen_a = '0;
  logic [31:0] seen_b = '0;
  logic [32:0] pend_q = '0;
  logic [31:0] pend_r = '0;

  initial begin
    bus.core_finish = 1'b0;
    bus.core_quo    = '0;
    bus.core_rem    = '0;
    forever begin
      @(negedge clk);
      if (bus.core_start) begin
        start_cnt++;
        seen_a = bus.core_dividend;
        seen_b = bus.core_divisor;
        pend_q = (bus.core_divisor == 0) ? '1 : {1'b0, bus.core_dividend[31:0] / bus.core_divisor};
        pend_r = (bus.core_divisor == 0) ? '0 : bus.core_dividend[31:0] % bus.core_divisor;
        if (core_mode == 1) begin
          bus.core_quo = pend_q;
          bus.core_rem = pend_r;
        end else begin
          bus.core_finish = 1'b0;
          core_cnt = (core_mode == 0) ? CoreLat : 0;
        end
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          bus.core_finish = 1'b1;
          bus.core_quo    = pend_q;
          bus.core_rem    = pend_r;
        end
      end
      if (core_mode == 1) bus.core_finish = 1'b1;
      if (core_mode == 2) bus.core_finish = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request; lat = 1 when resp_valid is visible right after the accept edge.
  task automatic do_req(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_signed   = s;
    bus.req_dividend = a;
    bus.req_divisor  = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < int'(T) + 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  typedef struct {
    logic        s;
    logic [31:0] a, b, q, r;
    logic        dz, ov;
    int          lat;
    logic [31:0] ca, cb;
  } vec_t;

  vec_t vecs[11];
  int   lat;
  int   s0;
  logic seen_valid;

  initial begin
    vecs[0]  = '{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 8, 32'd100, 32'd7};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 8,
                 32'd7, 32'd2};
    vecs[2]  = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, 8, 32'd7, 32'd2};
    vecs[3]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 1'b0, 8,
                 32'd7, 32'd2};
    vecs[4]  = '{1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1,
                 32'd0, 32'd0};
    vecs[5]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1,
                 32'd0, 32'd0};
    vecs[6]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 8,
                 32'h8000_0000, 32'hFFFF_FFFF};
    vecs[7]  = '{1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1, 32'd0, 32'd0};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1,
                 32'd0, 32'd0};
    vecs[9]  = '{1'b1, 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0, 1'b0, 8,
                 32'h8000_0000, 32'd2};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0, 1'b0, 8,
                 32'hFFFF_FFFF, 32'd16};

    rst              = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_signed   = 1'b0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.resp_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_core_start", 64'(bus.core_start), 64'd0);
    chk("rst_resp_quo", 64'(bus.resp_quo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      s0 = start_cnt;
      do_req(vecs[i].s, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_quo", i), 64'(bus.resp_quo), 64'(vecs[i].q));
      chk($sformatf("v%0d_rem", i), 64'(bus.resp_rem), 64'(vecs[i].r));
      chk($sformatf("v%0d_div_zero", i), 64'(bus.resp_div_zero), 64'(vecs[i].dz));
      chk($sformatf("v%0d_overflow", i), 64'(bus.resp_overflow), 64'(vecs[i].ov));
      chk($sformatf("v%0d_timeout", i), 64'(bus.resp_timeout), 64'd0);
      chk($sformatf("v%0d_starts", i), 64'(start_cnt - s0), (vecs[i].lat == 1) ? 64'd0 : 64'd1);
      if (vecs[i].lat != 1) begin
        chk($sformatf("v%0d_core_dividend", i), seen_a, {32'd0, vecs[i].ca});
        chk($sformatf("v%0d_core_divisor", i), 64'(seen_b), 64'(vecs[i].cb));
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid_drop", i), 64'(bus.resp_valid), 64'd0);
      chk($sformatf("v%0d_flags_clear", i),
          64'({bus.resp_div_zero, bus.resp_overflow, bus.resp_timeout}), 64'd0);
      chk($sformatf("v%0d_req_ready", i), 64'(bus.req_ready), 64'd1);
    end

    // Backpressure: result held for 10 cycles while resp_ready is low.
    bus.resp_ready = 1'b0;
    do_req(1'b0, 32'd100, 32'd7, lat);
    chk("bp_latency", 64'(lat), 64'd8);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_valid", k), 64'(bus.resp_valid), 64'd1);
      chk($sformatf("bp%0d_quo", k), 64'(bus.resp_quo), 64'd14);
      chk($sformatf("bp%0d_rem", k), 64'(bus.resp_rem), 64'd2);
      chk($sformatf("bp%0d_req_ready", k), 64'(bus.req_ready), 64'd0);
    end
    @(negedge clk);
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_drop", 64'(bus.resp_valid), 64'd0);
    chk("bp_req_ready", 64'(bus.req_ready), 64'd1);

    // Finish stuck high: first WAIT cycle ignored, capture on the second.
    core_mode = 1;
    do_req(1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    chk("hi_latency", 64'(lat), 64'd5);
    chk("hi_quo", 64'(bus.resp_quo), 64'hFFFF_FFFD);
    chk("hi_rem", 64'(bus.resp_rem), 64'hFFFF_FFFF);
    @(posedge clk);
    #1;

    // Finish stuck low: timeout after T WAIT cycles.
    core_mode = 2;
    do_req(1'b0, 32'd100, 32'd7, lat);
    chk("to_latency", 64'(lat), 64'(T + 2));
    chk("to_flag", 64'(bus.resp_timeout), 64'd1);
    chk("to_quo", 64'(bus.resp_quo), 64'd0);
    chk("to_rem", 64'(bus.resp_rem), 64'd0);
    chk("to_div_zero", 64'(bus.resp_div_zero), 64'd0);
    @(posedge clk);
    #1;

    // Reset while in WAIT; the core's later finish must not produce a response.
    core_mode = 0;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_signed   = 1'b0;
    bus.req_dividend = 32'd100;
    bus.req_divisor  = 32'd7;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wr_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("wr_req_ready", 64'(bus.req_ready), 64'd1);
    chk("wr_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("wr_busy", 64'(bus.busy), 64'd0);
    chk("wr_core_start", 64'(bus.core_start), 64'd0);
    chk("wr_core_dividend", bus.core_dividend, 64'd0);
    chk("wr_core_divisor", 64'(bus.core_divisor), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.resp_valid || bus.core_start) seen_valid = 1'b1;
    end
    chk("wr_core_finished", 64'(bus.core_finish), 64'd1);
    chk("wr_no_resp", 64'(seen_valid), 64'd0);

    // Normal operation resumes after the reset.
    do_req(1'b1, 32'd7, 32'hFFFF_FFFE, lat);
    chk("post_latency", 64'(lat), 64'd8);
    chk("post_quo", 64'(bus.resp_quo), 64'hFFFF_FFFD);
    chk("post_rem", 64'(bus.resp_rem), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
